tx_unit: RTL and testbench
==========================

Name: tx_unit

Overview:
- Serial transmitter paired with the MiniUART receive unit.
- Accepts one 8-bit byte from the CPU-side register interface and shifts it out on TxD, LSB first: 1 start bit, 8 data bits, optional parity, STOP_BITS stop bits.
- Runs from the same 8x-oversample enable tick that clocks the receiver; divides it internally to bit rate.
- Exposes a transmit-status flag so the bus interface knows when a new byte may be written.

Parameters:
- DIV, 8, en_tx ticks per serial bit (power of two, 2..16).
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- en_tx  input  1  oversample enable tick (1-cycle pulse at DIV x baud)
- d_in  input  8  byte to transmit
- load  input  1  write strobe from bus interface; 1-cycle pulse
- txd  output  1  serial output (idle high)
- ts  output  1  transmit status: 1 = idle/ready, 0 = busy

Behaviour:
- Reset, asynchronous: txd=1, ts=1, fsm=IDLE, shift register=0, tick counter=0, bit counter=0.
- States: IDLE, START, BIT_SEND, PARITY (only with the optional feature), STOP.
- Load acceptance:
  - load is honoured only in IDLE, whether or not en_tx is asserted in that cycle.
  - On acceptance: shift register<=d_in, fsm<=START, tick counter<=0, bit counter<=7, ts<=0 at that edge.
  - load outside IDLE is ignored: no latch, no effect on the frame in flight.
- Timing base: outside IDLE, all state, txd, and counter updates happen only on clk edges with en_tx=1. en_tx=0 freezes everything.
- Bit periods:
  - Each bit lasts exactly DIV en_tx ticks.
  - On the tick where tick counter==0, txd is driven with the current state's bit: START→0, BIT_SEND→shift[0], PARITY→parity, STOP→1.
  - The tick counter increments modulo DIV.
  - On the tick where tick counter==DIV-1 the state advances.
- BIT_SEND: at each bit end, shift right and decrement the bit counter. The transition out happens when the bit counter==0 at bit end.
- STOP:
  - Lasts STOP_BITS x DIV ticks.
  - At its final tick: fsm<=IDLE, ts<=1, txd stays 1.
- Latency:
  - The first en_tx tick after the load cycle drives txd=0. A tick coinciding with load is not counted.
  - Frame length = (10 + parity + STOP_BITS-1) x DIV ticks.
- Back-to-back: a load in the first IDLE cycle after ts rises starts the next start bit on the following en_tx tick. There is no extra idle bit.
- Reset mid-frame: txd returns to 1 immediately and the partial frame is abandoned. The receiver recovers through its stop-bit check.
- txd is registered (glitch-free); ts is registered.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Parity bit = XOR of the 8 data bits (even parity), computed at load.
  - The PARITY state is inserted between BIT_SEND and STOP, lasting DIV ticks.
- Undefined: no PARITY state; BIT_SEND goes directly to STOP.

Decomposition:
- The shared UART header holds:
  - tx state encodings (IDLE=0, START=1, BIT_SEND=2, PARITY=3, STOP=4);
  - the default DIV value;
  - the UART_TX_PARITY_EN switch alongside the existing receiver constants.
- No sub-module is needed.
- The bit timer (tick counter plus bit-end strobe) may optionally be split out as tx_bit_timer; single module preferred.

Test Plan:
- Single frame: reset, DIV=8, en_tx every 4 clks; load 0x55. Required: txd=0 for 8 ticks, then 1,0,1,0,1,0,1,0 each held 8 ticks, then stop=1. ts=0 for 80 ticks, then 1.
- Back-to-back: load 0xA5, then 0x3C on the first cycle ts=1. Required: second start bit on the very next en_tx tick; bits 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
- Load while busy: load 0xFF mid-frame of 0x00. Required: 0x00 frame unaltered, 0xFF never transmitted, ts rises after 80 ticks.
- Reset mid-frame: assert rst during data bit 3 of 0x0F. Required: txd=1 and ts=1 asynchronously; a subsequent load of 0x81 transmits correctly.
- en_tx gating: hold en_tx low 50 clks during bit 5. Required: txd and counters frozen; frame resumes with bit-period tick counts intact.
- Loopback: txd drives the receive unit's rxd with a shared en_tx. Send 0x00, 0xFF, 0x5A, 0xC3. Required: receiver status asserts with d_out equal to each byte. With UART_TX_PARITY_EN, 0x07 yields parity bit 1 before stop.

Source files
------------

// File: rtl/tx_unit_pkg.sv
// Shared UART header: tx state encodings, default bit-rate divider and
// receiver constants.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit.
package tx_unit_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        BIT_SEND = 3'd2,
        PARITY   = 3'd3,
        STOP     = 3'd4
    } tx_state_t;

    localparam int DIV_DEFAULT   = 8;
    localparam int RX_OVERSAMPLE = 8;
    localparam int RX_DATA_BITS  = 8;

`ifdef UART_TX_PARITY_EN
    localparam bit TX_PARITY_EN = 1'b1;
`else
    localparam bit TX_PARITY_EN = 1'b0;
`endif

endpackage

// File: rtl/tx_unit.sv
// MiniUART transmit unit: 8N1 (or 8E1 with UART_TX_PARITY_EN), LSB first,
// one or two stop bits, timed by the receiver's oversample enable tick.
//
// state    | meaning
// IDLE     | txd high, ts=1, waiting for load
// START    | driving the start bit (0)
// BIT_SEND | driving shift[0], 8 data bits
// PARITY   | driving even parity (UART_TX_PARITY_EN only)
// STOP     | driving stop bit(s) (1), STOP_BITS x DIV ticks
module tx_unit
    import tx_unit_pkg::*;
#(
    parameter int DIV       = DIV_DEFAULT,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_tx,
    input  logic [7:0] d_in,
    input  logic       load,
    output logic       txd,
    output logic       ts
);

    localparam int              TW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(DIV - 1);
    localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_t     state;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          cur_bit;
    logic          bit_end;
`ifdef UART_TX_PARITY_EN
    logic          par;
`endif

    assign bit_end = (tick_cnt == TICK_LAST);

    // Line level belonging to the current state, latched into txd at bit start
    always_comb begin
        cur_bit = 1'b1;
        case (state)
            START:    cur_bit = 1'b0;
            BIT_SEND: cur_bit = shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY:   cur_bit = par;
`endif
            default:  cur_bit = 1'b1;
        endcase
    end

    // Frame sequencer: load accepted in IDLE on any clock, everything else
    // advances only on en_tx ticks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            txd      <= 1'b1;
            ts       <= 1'b1;
            shift    <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (load) begin
                shift    <= d_in;
                state    <= START;
                tick_cnt <= '0;
                bit_cnt  <= 3'd7;
                ts       <= 1'b0;
`ifdef UART_TX_PARITY_EN
                par      <= ^d_in;
`endif
            end
        end else if (en_tx) begin
            tick_cnt <= tick_cnt + TW'(1);
            if (tick_cnt == '0)
                txd <= cur_bit;
            if (bit_end) begin
                case (state)
                    START: state <= BIT_SEND;
                    BIT_SEND: begin
                        shift   <= {1'b0, shift[7:1]};
                        bit_cnt <= bit_cnt - 3'd1;
                        if (bit_cnt == 3'd0) begin
`ifdef UART_TX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                            bit_cnt <= STOP_LAST;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        state   <= STOP;
                        bit_cnt <= STOP_LAST;
                    end
`endif
                    STOP: begin
                        if (bit_cnt == 3'd0) begin
                            state <= IDLE;
                            ts    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt - 3'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_unit.sv
// Directed testbench for tx_unit (DIV=8, STOP_BITS=1, en_tx every 4 clks).
// Honours UART_TX_PARITY_EN when defined.
module tb_tx_unit;

    localparam int DIV = 8;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NBITS  = 10 + PAR;
    localparam int NTICKS = NBITS * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_tx = 1'b0;
    logic [7:0] d_in = 8'h00;
    logic       load = 1'b0;
    logic       txd;
    logic       ts;

    bit gate = 1'b1;
    int en_cnt = 0;
    int total = 0;
    int passed = 0;

    tx_unit #(.DIV(DIV), .STOP_BITS(1)) dut (
        .clk   (clk),
        .rst   (rst),
        .en_tx (en_tx),
        .d_in  (d_in),
        .load  (load),
        .txd   (txd),
        .ts    (ts)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            en_cnt++;
            en_tx = gate && (en_cnt % 4 == 0);
        end
    end

    // Advance to just after the next clock edge that carried en_tx
    task automatic tick();
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < 2000) begin
            @(posedge clk);
            seen = en_tx;
            #1;
            load = 1'b0;
            n++;
        end
        if (!seen) begin
            total++;
            $display("FAIL tick_timeout: no en_tx edge within %0d clks", n);
        end
    endtask

    task automatic do_load(input logic [7:0] b);
        d_in = b;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (PAR == 1 && idx == 9) return ^b;
        return 1'b1;
    endfunction

    // Check txd and ts on every tick of one frame. Optional actions:
    // inj_tick: pulse load=0xFF after that tick; gate_tick: stop en_tx for
    // 50 clks after that tick; abort_tick: return after that tick.
    task automatic check_frame(input string nm, input logic [7:0] b,
                               input int inj_tick, input int gate_tick,
                               input int abort_tick);
        logic exp_txd, exp_ts, held;
        for (int t = 1; t <= NTICKS; t++) begin
            tick();
            exp_txd = frame_bit(b, (t - 1) / DIV);
            exp_ts  = (t == NTICKS);
            total++;
            if (txd !== exp_txd)
                $display("FAIL %s_txd tick %0d: got %b want %b", nm, t, txd, exp_txd);
            else passed++;
            total++;
            if (ts !== exp_ts)
                $display("FAIL %s_ts tick %0d: got %b want %b", nm, t, ts, exp_ts);
            else passed++;
            if (t == inj_tick) begin
                d_in = 8'hFF;
                load = 1'b1;
            end
            if (t == gate_tick) begin
                held = txd;
                gate = 1'b0;
                repeat (50) @(negedge clk);
                total++;
                if (txd !== held || ts !== 1'b0)
                    $display("FAIL %s_frozen: got txd=%b ts=%b want txd=%b ts=0", nm, txd, ts, held);
                else passed++;
                gate = 1'b1;
            end
            if (t == abort_tick) return;
        end
    endtask

    task automatic check_idle(input string nm, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            total++;
            if (txd !== 1'b1 || ts !== 1'b1)
                $display("FAIL %s idle tick %0d: got txd=%b ts=%b want 1 1", nm, i, txd, ts);
            else passed++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (txd !== 1'b1 || ts !== 1'b1)
            $display("FAIL reset_state: got txd=%b ts=%b want 1 1", txd, ts);
        else passed++;
        rst = 1'b0;
        check_idle("post_reset", 4);
    endtask

    task automatic test_single_frame();
        do_load(8'h55);
        check_frame("f55", 8'h55, 0, 0, 0);
        check_idle("f55_after", 2);
    endtask

    task automatic test_back_to_back();
        do_load(8'hA5);
        check_frame("bbA5", 8'hA5, 0, 0, 0);
        do_load(8'h3C);
        check_frame("bb3C", 8'h3C, 0, 0, 0);
    endtask

    task automatic test_load_busy();
        do_load(8'h00);
        check_frame("busy00", 8'h00, 20, 0, 0);
        check_idle("busy_noFF", 2 * NTICKS / DIV * DIV / 8);
    endtask

    task automatic test_reset_mid();
        do_load(8'h0F);
        check_frame("rst0F", 8'h0F, 0, 0, 36);
        rst = 1'b1;
        #1;
        total++;
        if (txd !== 1'b1 || ts !== 1'b1)
            $display("FAIL reset_mid_async: got txd=%b ts=%b want 1 1", txd, ts);
        else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_load(8'h81);
        check_frame("after_rst81", 8'h81, 0, 0, 0);
    endtask

    task automatic test_en_gating();
        do_load(8'h96);
        check_frame("gate96", 8'h96, 0, 52, 0);
    endtask

    // Bench-side receiver: mid-bit sampling on the shared en_tx tick
    task automatic test_loopback(input logic [7:0] b);
        logic [7:0] rx;
        int n = 0;
        do_load(b);
        tick();
        while (txd !== 1'b0 && n < 20) begin tick(); n++; end
        repeat (3) tick();
        total++;
        if (txd !== 1'b0) $display("FAIL lb_start %h: got %b want 0", b, txd);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) tick();
            rx[i] = txd;
        end
`ifdef UART_TX_PARITY_EN
        repeat (DIV) tick();
        total++;
        if (txd !== ^b) $display("FAIL lb_parity %h: got %b want %b", b, txd, ^b);
        else passed++;
        if (b == 8'h07) begin
            total++;
            if (txd !== 1'b1) $display("FAIL lb_parity_07: got %b want 1", txd);
            else passed++;
        end
`endif
        repeat (DIV) tick();
        total++;
        if (txd !== 1'b1) $display("FAIL lb_stop %h: got %b want 1", b, txd);
        else passed++;
        total++;
        if (rx !== b) $display("FAIL lb_data: got %h want %h", rx, b);
        else passed++;
        n = 0;
        while (ts !== 1'b1 && n < 20) begin tick(); n++; end
        total++;
        if (ts !== 1'b1) $display("FAIL lb_ts %h: got %b want 1", b, ts);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_load_busy();
        test_reset_mid();
        test_en_gating();
        test_loopback(8'h00);
        test_loopback(8'hFF);
        test_loopback(8'h5A);
        test_loopback(8'hC3);
`ifdef UART_TX_PARITY_EN
        test_loopback(8'h07);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
